// File: rtl/sm83_mem_pkg.sv
// Shared memory-side types for the SM83 ROM path:
// bus width defaults, ownership state encoding and port ids.
package sm83_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// ROM_LAT-deep valid/owner shift register that tracks every
// in-flight ROM read and decodes the per-port rvalid strobes.
module rom_arb_tag_pipe
  import sm83_mem_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     issue,
  input  port_id_t issue_id,
  output logic     p0_rvalid,
  output logic     p1_rvalid
);

  logic [ROM_LAT-1:0] vld_q;
  logic [ROM_LAT-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= issue;
      tag_q[0] <= issue_id;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  logic     out_vld;
  port_id_t out_tag;

  assign out_vld = vld_q[ROM_LAT-1];
  assign out_tag = tag_q[ROM_LAT-1];

  assign p0_rvalid = out_vld & (out_tag == PORT0);
  assign p1_rvalid = out_vld & (out_tag == PORT1);

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of the single-port block ROM.
// Define ROM_ARB_RR_EN for round-robin; default is fixed priority.
module rom_port_arbiter
  import sm83_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  own_state_t        state_q;
  own_state_t        state_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic              idle_win1;

`ifdef ROM_ARB_RR_EN
  // rr_ptr names the port that wins the next IDLE conflict
  port_id_t rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= PORT0;
    end else if (p1_gnt) begin
      rr_ptr_q <= PORT0;
    end else if (p0_gnt) begin
      rr_ptr_q <= PORT1;
    end
  end

  assign idle_win1 = p1_req & (~p0_req | (rr_ptr_q == PORT1));
`else
  assign idle_win1 = p1_req & ~p0_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (p0_gnt && p0_lock) begin
          state_d = OWN0;
        end else if (p1_gnt && p1_lock) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        state_d = (p0_req && p0_lock) ? OWN0 : IDLE;
      end
      OWN1: begin
        state_d = (p1_req && p1_lock) ? OWN1 : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          p1_gnt = idle_win1;
          p0_gnt = p0_req & ~idle_win1;
        end
        OWN0: begin
          p0_gnt = p0_req;
        end
        OWN1: begin
          p1_gnt = p1_req;
        end
        default: begin
          p0_gnt = 1'b0;
          p1_gnt = 1'b0;
        end
      endcase
    end
  end

  // Keep addra steady across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr_q <= '0;
    end else if (rom_en) begin
      last_addr_q <= rom_addr;
    end
  end

  assign rom_en = p0_gnt | p1_gnt;

  always_comb begin
    rom_addr = last_addr_q;
    if (p1_gnt) begin
      rom_addr = p1_addr;
    end else if (p0_gnt) begin
      rom_addr = p0_addr;
    end
  end

  rom_arb_tag_pipe #(
    .ROM_LAT(ROM_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .issue    (rom_en),
    .issue_id (p1_gnt ? PORT1 : PORT0),
    .p0_rvalid(p0_rvalid),
    .p1_rvalid(p1_rvalid)
  );

  // douta is only meaningful while a read is landing
  assign rdata = (p0_rvalid | p1_rvalid) ? rom_data : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: one ROM_LAT=1 and one
// ROM_LAT=3 instance, each behind a ROM model returning addr^A5A5A5A5.
module tb_rom_port_arbiter;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic        a_p0_req, a_p0_lock, a_p0_gnt, a_p0_rvalid;
  logic        a_p1_req, a_p1_lock, a_p1_gnt, a_p1_rvalid;
  logic [31:0] a_p0_addr, a_p1_addr, a_rdata, a_rom_addr, a_rom_data;
  logic        a_rom_en;

  logic        b_p0_req, b_p0_lock, b_p0_gnt, b_p0_rvalid;
  logic        b_p1_req, b_p1_lock, b_p1_gnt, b_p1_rvalid;
  logic [31:0] b_p0_addr, b_p1_addr, b_rdata, b_rom_addr, b_rom_data;
  logic        b_rom_en;

  rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(a_p0_req), .p0_lock(a_p0_lock), .p0_addr(a_p0_addr),
    .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid),
    .p1_req(a_p1_req), .p1_lock(a_p1_lock), .p1_addr(a_p1_addr),
    .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid),
    .rdata(a_rdata), .rom_en(a_rom_en), .rom_addr(a_rom_addr),
    .rom_data(a_rom_data)
  );

  rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_lock(b_p0_lock), .p0_addr(b_p0_addr),
    .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid),
    .p1_req(b_p1_req), .p1_lock(b_p1_lock), .p1_addr(b_p1_addr),
    .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid),
    .rdata(b_rdata), .rom_en(b_rom_en), .rom_addr(b_rom_addr),
    .rom_data(b_rom_data)
  );

  logic [31:0] a_q = '0;
  logic [31:0] b_d0 = '0, b_d1 = '0, b_d2 = '0;

  always @(posedge clk) begin
    if (a_rom_en) a_q <= a_rom_addr ^ K;
    if (b_rom_en) b_d0 <= b_rom_addr ^ K;
    b_d1 <= b_d0;
    b_d2 <= b_d1;
  end

  assign a_rom_data = a_q;
  assign b_rom_data = b_d2;

  task automatic test_reset();
    rst = 1'b1;
    a_p0_req = 1'b1; a_p0_lock = 1'b0; a_p0_addr = 32'h40;
    a_p1_req = 1'b0; a_p1_lock = 1'b0; a_p1_addr = 32'h0;
    b_p0_req = 1'b0; b_p0_lock = 1'b0; b_p0_addr = 32'h0;
    b_p1_req = 1'b0; b_p1_lock = 1'b0; b_p1_addr = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_rom_en} !== 5'b0) begin
        fails++;
        $display("FAIL reset_ctl c%0d: got %b want 00000", c,
                 {a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_rom_en});
      end
      checks++;
      if (a_rom_addr !== 32'h0 || a_rdata !== 32'h0) begin
        fails++;
        $display("FAIL reset_bus c%0d: addr %h rdata %h want 0", c, a_rom_addr, a_rdata);
      end
      @(posedge clk);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_p0_gnt !== 1'b1 || a_rom_addr !== 32'h40) begin
      fails++;
      $display("FAIL first_gnt: gnt %b addr %h want 1 40", a_p0_gnt, a_rom_addr);
    end
    @(posedge clk);
    #1 a_p0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_p0_rvalid !== 1'b1 || a_rdata !== (32'h40 ^ K)) begin
      fails++;
      $display("FAIL post_reset_read: rv %b rdata %h want 1 %h", a_p0_rvalid, a_rdata, 32'h40 ^ K);
    end
  endtask

  task automatic test_single();
    @(posedge clk);
    #1 a_p0_req = 1'b1; a_p0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (a_p0_gnt !== 1'b1 || a_p1_gnt !== 1'b0 || a_rom_en !== 1'b1 || a_rom_addr !== 32'h10) begin
      fails++;
      $display("FAIL single_issue: g0 %b g1 %b en %b addr %h want 1 0 1 10",
               a_p0_gnt, a_p1_gnt, a_rom_en, a_rom_addr);
    end
    @(posedge clk);
    #1 a_p0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_p0_rvalid !== 1'b1 || a_p1_rvalid !== 1'b0 || a_rdata !== 32'hA5A5A5B5) begin
      fails++;
      $display("FAIL single_resp: rv0 %b rv1 %b rdata %h want 1 0 a5a5a5b5",
               a_p0_rvalid, a_p1_rvalid, a_rdata);
    end
    checks++;
    if (a_rom_en !== 1'b0 || a_rom_addr !== 32'h10 || a_p0_gnt !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: en %b addr %h gnt %b want 0 10 0", a_rom_en, a_rom_addr, a_p0_gnt);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (a_p0_rvalid !== 1'b0 || a_rdata !== 32'h0) begin
      fails++;
      $display("FAIL single_drain: rv %b rdata %h want 0 0", a_p0_rvalid, a_rdata);
    end
  endtask

  task automatic test_conflict();
    logic e0, e1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    a_p0_req = 1'b1; a_p0_addr = 32'h20;
    a_p1_req = 1'b1; a_p1_addr = 32'h30;
    for (int c = 0; c < 4; c++) begin
`ifdef ROM_ARB_RR_EN
      e0 = (c % 2 == 0);
`else
      e0 = 1'b1;
`endif
      e1 = ~e0;
      @(negedge clk);
      checks++;
      if (a_p0_gnt !== e0 || a_p1_gnt !== e1) begin
        fails++;
        $display("FAIL conflict_gnt c%0d: got %b%b want %b%b", c, a_p0_gnt, a_p1_gnt, e0, e1);
      end
      checks++;
      if (a_rom_addr !== (e0 ? 32'h20 : 32'h30)) begin
        fails++;
        $display("FAIL conflict_addr c%0d: got %h want %h", c, a_rom_addr, e0 ? 32'h20 : 32'h30);
      end
      @(posedge clk);
      #1;
    end
    a_p0_req = 1'b0; a_p1_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_burst_lock();
    logic [3:0] lk;
    lk = 4'b0111;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      a_p0_req  = (c >= 1);
      a_p0_addr = 32'h50;
      a_p1_req  = (c <= 3);
      a_p1_lock = (c <= 3) ? lk[c] : 1'b0;
      a_p1_addr = 32'h60 + c;
      @(negedge clk);
      checks++;
      if (a_p1_gnt !== (c <= 3) || a_p0_gnt !== (c == 4)) begin
        fails++;
        $display("FAIL burst_gnt beat%0d: g0 %b g1 %b want %b %b",
                 c, a_p0_gnt, a_p1_gnt, c == 4, c <= 3);
      end
    end
    @(posedge clk);
    #1 a_p0_req = 1'b0; a_p1_req = 1'b0; a_p1_lock = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      b_p0_req  = (c < 3);
      b_p0_addr = c;
      exp_d = (c >= 3 && c <= 5) ? ((c - 3) ^ K) : 32'h0;
      @(negedge clk);
      checks++;
      if (b_p0_gnt !== (c < 3)) begin
        fails++;
        $display("FAIL b2b_gnt c%0d: got %b want %b", c, b_p0_gnt, c < 3);
      end
      checks++;
      if (b_p0_rvalid !== (c >= 3 && c <= 5) || b_p1_rvalid !== 1'b0 || b_rdata !== exp_d) begin
        fails++;
        $display("FAIL b2b_resp c%0d: rv0 %b rv1 %b rdata %h want %b 0 %h",
                 c, b_p0_rvalid, b_p1_rvalid, b_rdata, c >= 3 && c <= 5, exp_d);
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk);
    #1 b_p0_req = 1'b1; b_p0_addr = 32'h5;
    @(negedge clk);
    checks++;
    if (b_p0_gnt !== 1'b1) begin
      fails++;
      $display("FAIL mid_gnt: got %b want 1", b_p0_gnt);
    end
    @(posedge clk);
    #1 b_p0_req = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (b_p0_rvalid !== 1'b0 || b_p1_rvalid !== 1'b0 || b_rdata !== 32'h0) begin
        fails++;
        $display("FAIL mid_flush c%0d: rv0 %b rv1 %b rdata %h want 0 0 0",
                 c, b_p0_rvalid, b_p1_rvalid, b_rdata);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_burst_lock();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
